tdc_readout_scanner: RTL and testbench

On-chip readout block that captures the four 8-bit measurement channels (sensor, TDC, RO, RO2) as one coherent snapshot and sends them off-chip as a framed UART byte stream on a single pin. The block sits beside the output mux. The mux lets an external host pick one channel at a time through `sel`. This block instead does the scanning and serialization on-chip, so the host only needs one receive line. It is clocked by the system clock.

---
 rtl/tdc_readout_pkg.sv | 39 +++
 rtl/tdc_readout_scanner_uart_tx_byte.sv | 101 ++++++++++
 rtl/tdc_readout_scanner.sv | 87 ++++++++
 tb/tb_tdc_readout_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tdc_readout_pkg.sv
// Shared types and frame constants for the TDC readout scanner.
// The READOUT_CHECKSUM_EN macro appends an XOR checksum byte to every frame.
package tdc_readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [7:0]  FRAME_HDR = 8'hA5;
    localparam int unsigned CH_COUNT  = 4;
    localparam int unsigned CH_W      = 8 * CH_COUNT;
`ifdef READOUT_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES = 6;
`else
    localparam int unsigned FRAME_BYTES = 5;
`endif

    // Byte at position idx of a frame built from the snapshot.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [CH_W-1:0] snap);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = FRAME_HDR;
            3'd1:    b = snap[7:0];
            3'd2:    b = snap[15:8];
            3'd3:    b = snap[23:16];
            3'd4:    b = snap[31:24];
`ifdef READOUT_CHECKSUM_EN
            3'd5:    b = FRAME_HDR ^ snap[7:0] ^ snap[15:8] ^ snap[23:16] ^ snap[31:24];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/tdc_readout_scanner_uart_tx_byte.sv
// Single-byte UART transmitter: start bit, 8 data bits LSB first, stop bit.
// A load on the final stop-bit cycle chains the next byte with no idle gap.
module uart_tx_byte
    import tdc_readout_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] byte_in_i,
    output logic       tx_o,
    output logic       byte_done_c
);

    localparam int unsigned    CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             tick_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_done_c = 1'b0;
        tick_c      = (cnt_q == CNT_LAST);

        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    shift_d = byte_in_i;
                end
            end
            ST_START: begin
                cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
                if (tick_c) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                end
            end
            ST_DATA: begin
                cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
                if (tick_c) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            ST_STOP: begin
                cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
                if (tick_c) begin
                    byte_done_c = 1'b1;
                    if (load_i) begin
                        state_d = ST_START;
                        shift_d = byte_in_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level follows the state being entered so tx stays registered.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/tdc_readout_scanner.sv
// Snapshots four synchronized channel bytes and sends them as a framed UART stream.
// Define READOUT_CHECKSUM_EN to append an XOR checksum byte to each frame.
module tdc_readout_scanner
    import tdc_readout_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH_W-1:0] ch_data,
    input  logic            start,
    output logic            tx,
    output logic            busy,
    output logic            frame_done
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    logic [CH_W-1:0] ch_meta_q, ch_sync_q;
    logic [CH_W-1:0] snap_q, snap_d;
    logic            busy_q, busy_d;
    logic [2:0]      idx_q, idx_d;
    logic            frame_done_q, frame_done_d;
    logic            accept_c, load_c, byte_done_c;
    logic [7:0]      byte_sel_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_meta_q    <= '0;
            ch_sync_q    <= '0;
            snap_q       <= '0;
            busy_q       <= 1'b0;
            idx_q        <= 3'd0;
            frame_done_q <= 1'b0;
        end else begin
            ch_meta_q    <= ch_data;
            ch_sync_q    <= ch_meta_q;
            snap_q       <= snap_d;
            busy_q       <= busy_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Frame sequencing: accept, chain the next byte, or close the frame.
    always_comb begin
        snap_d       = snap_q;
        busy_d       = busy_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        load_c       = 1'b0;
        accept_c     = !busy_q && start;

        if (accept_c) begin
            snap_d = ch_sync_q;
            busy_d = 1'b1;
            idx_d  = 3'd0;
            load_c = 1'b1;
        end else if (busy_q && byte_done_c) begin
            if (idx_q == LAST_IDX) begin
                busy_d       = 1'b0;
                frame_done_d = 1'b1;
            end else begin
                idx_d  = idx_q + 3'd1;
                load_c = 1'b1;
            end
        end

        // Index 0 is the constant header, so the stale snapshot is harmless on accept.
        byte_sel_c = frame_byte(idx_d, snap_q);
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load_c),
        .byte_in_i   (byte_sel_c),
        .tx_o        (tx),
        .byte_done_c (byte_done_c)
    );

    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tdc_readout_scanner.sv
// Randomized scoreboard bench: a UART receiver monitor checks decoded bytes against expected frames.
module tb_tdc_readout_scanner;

    localparam int C  = 4;
`ifdef READOUT_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif
    localparam int FRAME_CYC = NB * 10 * C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ch_data = 32'h0;
    logic        start = 1'b0;
    logic        tx, busy, frame_done;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];
    logic rx_ok;

    tdc_readout_scanner #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_data    (ch_data),
        .start      (start),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: header, channel bytes in order, optional XOR of everything before.
    task automatic push_frame(input logic [31:0] d);
        logic [7:0] x;
        x = 8'hA5;
        sb.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(d[8*i +: 8]);
            x = x ^ d[8*i +: 8];
        end
        if (NB == 6) sb.push_back(x);
    endtask

    task automatic rx_wait(input int n);
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) rx_ok = 1'b0;
        end
    endtask

    // Monitor: decode tx at mid-bit, abandon a byte cut short by reset.
    initial begin : monitor
        logic [7:0] b;
        logic s0, s1;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                rx_ok = 1'b1;
                rx_wait(C / 2);
                s0 = tx;
                for (int i = 0; i < 8; i++) begin
                    rx_wait(C);
                    b[i] = tx;
                end
                rx_wait(C);
                s1 = tx;
                if (rx_ok) begin
                    chk("start_bit", 32'(s0), 32'd0);
                    chk("stop_bit", 32'(s1), 32'd1);
                    if (sb.size() == 0) begin
                        chk("unexpected_byte", 32'(b), 32'hFFFF_FFFF);
                    end else begin
                        chk("rx_byte", 32'(b), 32'(sb.pop_front()));
                    end
                end
            end
        end
    end

    task automatic wait_done(input string name, input int from);
        int n;
        n = from;
        while (n < 4 * FRAME_CYC) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (frame_done) break;
        end
        chk(name, 32'(n), 32'(FRAME_CYC));
        chk("busy_low_at_done", 32'(busy), 32'd0);
    endtask

    task automatic send_frame(input logic [31:0] d, input bit disturb);
        int n;
        @(posedge clk); #1 ch_data = d;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        push_frame(d);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("tx_start_bit", 32'(tx), 32'd0);
        if (disturb) begin
            repeat (50) @(negedge clk);
            ch_data = 32'hFFFF_FFFF;
            start = 1'b1;
            repeat (2) @(negedge clk);
            start = 1'b0;
            chk("busy_held", 32'(busy), 32'd1);
            wait_done("frame_len_disturbed", 52);
        end else begin
            wait_done("frame_len", 0);
        end
    endtask

    initial begin : stim
        logic [31:0] d;
        int seen;
        // Reset held for three edges.
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("rst_tx", 32'(tx), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(frame_done), 32'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        send_frame(32'h7856_3412, 1'b0);

        // Frozen snapshot and ignored start while busy.
        send_frame(32'h7856_3412, 1'b1);
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy || frame_done || !tx) seen++;
        end
        chk("no_second_frame", 32'(seen), 32'd0);
        chk("sb_empty_after_frozen", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 6; i++) send_frame($urandom, 1'b0);

        // Continuous start: one idle-high cycle between frames.
        d = $urandom;
        @(posedge clk); #1 ch_data = d;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        push_frame(d);
        push_frame(d);
        @(posedge clk);
        @(negedge clk);
        chk("cont_busy1", 32'(busy), 32'd1);
        wait_done("cont_len1", 0);
        chk("cont_idle_tx", 32'(tx), 32'd1);
        @(negedge clk);
        chk("cont_busy2", 32'(busy), 32'd1);
        chk("cont_tx2", 32'(tx), 32'd0);
        start = 1'b0;
        wait_done("cont_len2", 0);

        // Reset during byte 2, then a clean frame.
        d = $urandom;
        @(posedge clk); #1 ch_data = d;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        push_frame(d);
        @(posedge clk); #1 start = 1'b0;
        repeat (2 * 10 * C + 15) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(frame_done), 32'd0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (FRAME_CYC + 20) begin
            @(negedge clk);
            if (frame_done || busy) seen++;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        send_frame($urandom, 1'b0);

        repeat (20) @(posedge clk);
        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
